// File: rtl/mouse_ps2_ctrl.sv
// PS/2 host mouse controller: enables reporting, then accumulates packets into x/y/button status.
// Latency: status word updates one cycle after the third packet byte's stop bit is sampled.
// Backpressure: none; the device owns the clock, and bad or stalled frames are dropped.
module mouse_ps2_ctrl #(
  parameter int INHIBIT_CYC = 2500,
  parameter int TIMEOUT_CYC = 25000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        msclk_in,
  input  logic        msdat_in,
  output logic        msclk_oe,
  output logic        msdat_oe,
  output logic        ready,
  output logic [27:0] out
);

  localparam int         CMAX    = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int         CW      = $clog2(CMAX + 1);
  localparam logic [7:0] CMD     = 8'hF4;   // enable data reporting
  localparam logic       CMD_PAR = ~^CMD;   // odd parity bit for the command
  localparam logic [7:0] ACK     = 8'hFA;

  typedef enum logic [1:0] {INHIBIT, TX, ACKRX, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;       // inhibit length in INHIBIT, idle time since last fall when receiving
  logic [3:0]    bitcnt;    // falls seen in the current frame
  logic [9:0]    rx_sh;     // first ten bits of the incoming frame, start bit ends up in [0]
  logic [1:0]    idx;       // packet byte index
  logic          commit;
  logic [2:0]    btn;       // {M, R, L} from byte 0
  logic          sx, sy, ox, oy;
  logic [7:0]    dx, dy;
  logic [9:0]    x, y;
  logic          ml, mm, mr;
  logic          clk_s1, clk_s2, clk_d, dat_s1, dat_s2;

  logic          fall;
  logic [10:0]   frame;
  logic          frame_ok;
  logic [7:0]    rx_byte;

  assign fall     = clk_d & ~clk_s2;
  assign frame    = {dat_s2, rx_sh};
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);
  assign rx_byte  = frame[8:1];
  assign out      = {1'b0, ml, mm, mr, 2'b00, y, 2'b00, x};

  // Two-flop synchronisers on the pins plus a delayed clock copy for edge detection; idle high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_d  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= msclk_in;
      clk_s2 <= clk_s1;
      clk_d  <= clk_s2;
      dat_s1 <= msdat_in;
      dat_s2 <= dat_s1;
    end
  end

  // Init/command/receive sequencer with packet assembly and the registered status update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INHIBIT;
      cnt      <= '0;
      bitcnt   <= '0;
      rx_sh    <= '0;
      idx      <= '0;
      commit   <= 1'b0;
      btn      <= '0;
      sx       <= 1'b0;
      sy       <= 1'b0;
      ox       <= 1'b0;
      oy       <= 1'b0;
      dx       <= '0;
      dy       <= '0;
      x        <= '0;
      y        <= '0;
      ml       <= 1'b0;
      mm       <= 1'b0;
      mr       <= 1'b0;
      msclk_oe <= 1'b0;
      msdat_oe <= 1'b0;
      ready    <= 1'b0;
    end else begin
      commit <= 1'b0;
      if (commit) begin
        ml <= btn[0];
        mr <= btn[1];
        mm <= btn[2];
        if (!ox) x <= x + {sx, sx, dx};
        if (!oy) y <= y + {sy, sy, dy};
      end
      case (state)
        INHIBIT: begin
          bitcnt <= '0;
          if (cnt == CW'(INHIBIT_CYC)) begin
            // release the clock with data already low: that is the start bit
            cnt      <= '0;
            msclk_oe <= 1'b0;
            msdat_oe <= 1'b1;
            state    <= TX;
          end else begin
            msclk_oe <= 1'b1;
            cnt      <= cnt + 1'b1;
          end
        end
        TX: begin
          if (fall) begin
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt < 4'd8) begin
              msdat_oe <= ~CMD[bitcnt[2:0]];
            end else if (bitcnt == 4'd8) begin
              msdat_oe <= ~CMD_PAR;
            end else if (bitcnt == 4'd9) begin
              msdat_oe <= 1'b0;
            end else begin
              // eleventh fall: device pulls data low to acknowledge
              bitcnt <= '0;
              cnt    <= '0;
              state  <= dat_s2 ? INHIBIT : ACKRX;
            end
          end
        end
        default: begin
          if (fall) begin
            cnt <= '0;
            if (bitcnt == 4'd10) begin
              bitcnt <= '0;
              if (state == ACKRX) begin
                if (frame_ok && rx_byte == ACK) begin
                  ready <= 1'b1;
                  idx   <= '0;
                  state <= RUN;
                end else begin
                  state <= INHIBIT;
                end
              end else if (!frame_ok) begin
                idx <= '0;
              end else begin
                case (idx)
                  2'd0: begin
                    // bit 3 is always set in a header byte; anything else means we are out of step
                    if (rx_byte[3]) begin
                      {oy, ox, sy, sx} <= rx_byte[7:4];
                      btn              <= rx_byte[2:0];
                      idx              <= 2'd1;
                    end
                  end
                  2'd1: begin
                    dx  <= rx_byte;
                    idx <= 2'd2;
                  end
                  default: begin
                    dy     <= rx_byte;
                    idx    <= '0;
                    commit <= 1'b1;
                  end
                endcase
              end
            end else begin
              bitcnt <= bitcnt + 1'b1;
              rx_sh  <= {dat_s2, rx_sh[9:1]};
            end
          end else if (bitcnt == 4'd0) begin
            cnt <= '0;
          end else if (cnt == CW'(TIMEOUT_CYC)) begin
            // device went quiet mid-frame: drop the partial frame and any partial packet
            bitcnt <= '0;
            cnt    <= '0;
            if (state == RUN) idx <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_ps2_ctrl.sv
// Bench for mouse_ps2_ctrl: emulates the PS/2 mouse and checks against a packet-level model.
// Latency: status compared after each full packet, once the stop bit has settled.
// Backpressure: device clock is bench-driven; every wait is bounded, with a global watchdog.
module tb_mouse_ps2_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dev_clk = 1'b1;
  logic        dev_dat = 1'b1;
  logic        msclk_in, msdat_in;
  logic        msclk_oe, msdat_oe, ready;
  logic [27:0] out;

  int checks   = 0;
  int failures = 0;
  int half     = 15;

  // packet-level reference model
  logic [9:0]  mx = '0, my = '0;
  logic        m_l = 1'b0, m_m = 1'b0, m_r = 1'b0;
  logic [7:0]  pkt[$];

  // open-collector lines: either side can pull low
  assign msclk_in = dev_clk & ~msclk_oe;
  assign msdat_in = dev_dat & ~msdat_oe;

  mouse_ps2_ctrl #(.INHIBIT_CYC(2500), .TIMEOUT_CYC(25000)) dut (
    .clk      (clk),
    .rst      (rst),
    .msclk_in (msclk_in),
    .msdat_in (msdat_in),
    .msclk_oe (msclk_oe),
    .msdat_oe (msdat_oe),
    .ready    (ready),
    .out      (out)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] model_out();
    return {1'b0, m_l, m_m, m_r, 2'b00, my, 2'b00, mx};
  endfunction

  function automatic logic [9:0] wrap_add(input logic [9:0] a, input int d);
    return 10'(((int'(a) + d) % 1024 + 1024) % 1024);
  endfunction

  task automatic model_reset();
    mx = '0; my = '0; m_l = 1'b0; m_m = 1'b0; m_r = 1'b0;
    pkt.delete();
  endtask

  // one received frame as the mouse protocol sees it
  task automatic model_frame(input logic [7:0] b, input bit ok);
    logic [7:0] h;
    int dxv, dyv;
    if (!ok) begin
      pkt.delete();
    end else if (!(pkt.size() == 0 && b[3] == 1'b0)) begin
      pkt.push_back(b);
      if (pkt.size() == 3) begin
        h = pkt[0];
        m_l = h[0]; m_r = h[1]; m_m = h[2];
        dxv = h[4] ? int'(pkt[1]) - 256 : int'(pkt[1]);
        dyv = h[5] ? int'(pkt[2]) - 256 : int'(pkt[2]);
        if (!h[6]) mx = wrap_add(mx, dxv);
        if (!h[7]) my = wrap_add(my, dyv);
        pkt.delete();
      end
    end
  endtask

  // device-to-host frame, optionally truncated after nbits clocks
  task automatic send_byte(input logic [7:0] b, input bit badpar, input int nbits);
    logic [10:0] f;
    f = {1'b1, (badpar ? ^b : ~^b), b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      dev_dat = f[i];
      cyc(half);
      dev_clk = 1'b0;
      cyc(half);
      dev_clk = 1'b1;
    end
    dev_dat = 1'b1;
    cyc(half);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit badpar);
    send_byte(b, badpar, 11);
    model_frame(b, !badpar);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_frame(b0, 1'b0);
    send_frame(b1, 1'b0);
    send_frame(b2, 1'b0);
  endtask

  task automatic chk_state(input string tag);
    check({tag, "_out"}, {4'h0, out}, {4'h0, model_out()});
    check({tag, "_ready"}, {31'h0, ready}, 32'd1);
  endtask

  // host inhibit + command transfer seen from the device side, then optional reply
  task automatic do_init(input bit measure, input bit ack_ok, input logic [7:0] reply);
    int wc, n;
    logic [9:0] bits;
    logic [7:0] cmd;
    cmd = 8'hF4; wc = 0; n = 0; bits = '0;
    cyc(1);
    while (!msclk_oe && wc < 10000) begin wc++; cyc(1); end
    if (measure) check("init_wait", wc, 0);
    while (msclk_oe && n < 10000) begin n++; cyc(1); end
    if (measure) check("inhibit_len", n, 2500);
    check("start_bit", {31'h0, msdat_oe}, 32'd1);
    cyc(half);
    for (int i = 1; i <= 11; i++) begin
      if (i == 11) dev_dat = ack_ok ? 1'b0 : 1'b1;
      dev_clk = 1'b0;
      cyc(half);
      if (i <= 10) bits[i-1] = msdat_in;
      dev_clk = 1'b1;
      cyc(half);
    end
    dev_dat = 1'b1;
    check("tx_byte", {24'h0, bits[7:0]}, {24'h0, cmd});
    check("tx_parity", {31'h0, bits[8]}, {31'h0, ~^cmd});
    check("tx_stop", {31'h0, bits[9]}, 32'd1);
    if (ack_ok) send_byte(reply, 1'b0, 11);
  endtask

  initial begin
    int r;
    logic [7:0] b0, junk;

    // reset values while held in reset
    cyc(3);
    check("rst_out", {4'h0, out}, 32'h0);
    check("rst_ready", {31'h0, ready}, 32'd0);
    check("rst_clk_oe", {31'h0, msclk_oe}, 32'd0);
    check("rst_dat_oe", {31'h0, msdat_oe}, 32'd0);
    rst = 1'b1;

    // attempt 1: no acknowledge -> back to inhibit
    do_init(1'b1, 1'b0, 8'h00);
    check("nack_inhibit", {31'h0, msclk_oe}, 32'd1);
    check("nack_ready", {31'h0, ready}, 32'd0);
    // attempt 2: acknowledged but reply is a resend request
    do_init(1'b0, 1'b1, 8'hFE);
    check("fe_inhibit", {31'h0, msclk_oe}, 32'd1);
    check("fe_ready", {31'h0, ready}, 32'd0);
    // attempt 3: proper acknowledge
    do_init(1'b0, 1'b1, 8'hFA);
    check("init_ready", {31'h0, ready}, 32'd1);
    check("init_out", {4'h0, out}, 32'h0);
    check("run_clk_oe", {31'h0, msclk_oe}, 32'd0);

    // movement
    send_pkt(8'h09, 8'h05, 8'hFD);
    chk_state("mv1");
    check("mv1_x", {22'h0, out[9:0]}, 32'd5);
    check("mv1_y", {22'h0, out[21:12]}, 32'd253);
    check("mv1_ml", {31'h0, out[26]}, 32'd1);
    send_pkt(8'h38, 8'hFB, 8'h03);
    chk_state("mv2");
    check("mv2_xy", {4'h0, out}, 32'h0);

    // wrap below zero, then overflow flag blocks movement
    send_pkt(8'h18, 8'hFF, 8'h00);
    chk_state("wrap");
    check("wrap_x", {22'h0, out[9:0]}, 32'd1023);
    send_pkt(8'h48, 8'h7F, 8'h00);
    chk_state("ovf");
    check("ovf_x", {22'h0, out[9:0]}, 32'd1023);

    // resync: header without bit 3 is dropped
    send_frame(8'h00, 1'b0);
    send_pkt(8'h08, 8'h01, 8'h01);
    chk_state("resync");
    check("resync_xy", {4'h0, out}, {4'h0, 1'b0, 3'b000, 2'b00, 10'd1, 2'b00, 10'd0});

    // bad parity mid-packet discards the partial packet
    send_frame(8'h08, 1'b0);
    send_frame(8'h10, 1'b1);
    chk_state("badpar_hold");
    send_pkt(8'h08, 8'h02, 8'h02);
    chk_state("badpar");

    // stall after four bits longer than the timeout
    send_frame(8'h08, 1'b0);
    send_byte(8'h55, 1'b0, 4);
    cyc(26000);
    pkt.delete();
    chk_state("tmo_hold");
    send_pkt(8'h08, 8'h03, 8'h04);
    chk_state("tmo");

    // randomized packets with occasional junk headers and corrupted frames
    for (int it = 0; it < 12; it++) begin
      half = $urandom_range(8, 20);
      r    = $urandom_range(0, 9);
      b0   = 8'($urandom) | 8'h08;
      if (r == 0) begin
        junk = 8'($urandom) & 8'hF7;
        send_frame(junk, 1'b0);
      end
      if (r == 1) begin
        send_frame(b0, 1'b0);
        send_frame(8'($urandom), 1'b1);
      end
      send_pkt(b0, 8'($urandom), 8'($urandom));
      chk_state("rnd");
    end

    // asynchronous reset in the middle of a frame
    half = 15;
    send_pkt(8'h09, 8'h05, 8'h07);
    chk_state("pre_rst");
    send_byte(8'h33, 1'b0, 4);
    rst = 1'b0;
    #1;
    check("arst_out", {4'h0, out}, 32'h0);
    check("arst_ready", {31'h0, ready}, 32'd0);
    model_reset();
    cyc(3);
    rst = 1'b1;
    do_init(1'b1, 1'b1, 8'hFA);
    check("reinit_ready", {31'h0, ready}, 32'd1);
    check("reinit_out", {4'h0, out}, 32'h0);
    send_pkt(8'h0A, 8'h11, 8'h22);
    chk_state("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
